safe_lock_ctrl: RTL and testbench



---
 rtl/safe_lock_pkg.sv | 37 +++
 rtl/safe_lock_ctrl_timer.sv | 42 ++++
 rtl/safe_lock_ctrl.sv | 168 ++++++++++++++++
 tb/tb_safe_lock_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/safe_lock_pkg.sv
// safe_lock_pkg
//   Shared types and width helpers for the safe lock controller.
//   lock_state_t : controller state encoding (2'b11 is unused/illegal)
//   fail_w()     : width of the consecutive-failure counter
//   timer_w()    : width of the shared unlock/lockout down-counter
package safe_lock_pkg;

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        UNLOCKED = 2'd1,
        LOCKOUT  = 2'd2
    } lock_state_t;

    localparam int DEF_MAX_ATTEMPTS   = 3;
    localparam int DEF_UNLOCK_CYCLES  = 16;
    localparam int DEF_LOCKOUT_CYCLES = 64;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Never return zero so a degenerate parameter set still builds.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Counter must hold 0..max_attempts
    function automatic int fail_w(input int max_attempts);
        return safe_clog2(max_attempts + 1);
    endfunction

    // Timer holds at most max(unlock, lockout) - 1
    function automatic int timer_w(input int unlock_cycles, input int lockout_cycles);
        return safe_clog2(max2(unlock_cycles, lockout_cycles));
    endfunction

endpackage

// File: rtl/safe_lock_ctrl_timer.sv
// lock_timer
//   Loadable down-counter shared by the UNLOCKED and LOCKOUT states.
//   Ports:
//     clk        : system clock
//     rst        : synchronous active-high reset (count -> 0)
//     load_i     : load load_val_i this cycle (wins over en_i)
//     load_val_i : value to load
//     en_i       : decrement by one; holds at zero
//     zero_o     : count is zero
module lock_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign zero_o = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && !zero_o) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/safe_lock_ctrl.sv
// safe_lock_ctrl
//   Sits behind the serial code checker. Turns per-attempt verdicts into a
//   timed unlock pulse, a consecutive-failure counter and a timed lockout,
//   and gates further keypad input while unlocked or locked out.
//   Optional feature macro: SAFE_LOCK_ALARM_EN (adds sticky alarm output).
//   Ports:
//     clk         : system clock
//     rst         : synchronous active-high reset
//     result_val  : checker verdict valid (may stay high 2+ cycles per attempt)
//     result_data : 1 = correct code, 0 = wrong code
//     relock      : door closed; ends an unlock early
//     input_en    : 1 = checker may accept serial bits
//     unlock      : solenoid drive
//     lockout     : lockout indicator
//     fail_cnt    : consecutive wrong codes so far
//     alarm       : (SAFE_LOCK_ALARM_EN only) set on lockout entry, cleared
//                   by a correct code or reset
module safe_lock_ctrl
    import safe_lock_pkg::*;
#(
    parameter int  MAX_ATTEMPTS   = DEF_MAX_ATTEMPTS,
    parameter int  UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
    parameter int  LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    localparam int FW             = fail_w(MAX_ATTEMPTS),
    localparam int TW             = timer_w(UNLOCK_CYCLES, LOCKOUT_CYCLES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          result_val,
    input  logic          result_data,
    input  logic          relock,
    output logic          input_en,
    output logic          unlock,
    output logic          lockout,
`ifdef SAFE_LOCK_ALARM_EN
    output logic [FW-1:0] fail_cnt,
    output logic          alarm
`else
    output logic [FW-1:0] fail_cnt
`endif
);

    localparam logic [FW-1:0] FAIL_LAST  = FW'(MAX_ATTEMPTS - 1);
    localparam logic [TW-1:0] UNLOCK_LD  = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] LOCKOUT_LD = TW'(LOCKOUT_CYCLES - 1);

    lock_state_t   state_q, state_d;
    logic [FW-1:0] fail_q, fail_d;
    logic          result_val_q;
    logic          input_en_q, unlock_q, lockout_q;
    logic          tmr_load, tmr_en, tmr_zero;
    logic [TW-1:0] tmr_val;
`ifdef SAFE_LOCK_ALARM_EN
    logic          alarm_q, alarm_d;
`endif

    // One attempt may hold result_val for several cycles; only its first
    // cycle counts, and a level still high on return to ARMED is ignored.
    logic qual;
    assign qual = result_val && !result_val_q;

    lock_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        fail_d   = fail_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_en   = 1'b0;
`ifdef SAFE_LOCK_ALARM_EN
        alarm_d  = alarm_q;
`endif
        case (state_q)
            ARMED: begin
                if (qual) begin
                    if (result_data) begin
                        fail_d   = '0;
                        tmr_load = 1'b1;
                        tmr_val  = UNLOCK_LD;
                        state_d  = UNLOCKED;
`ifdef SAFE_LOCK_ALARM_EN
                        alarm_d  = 1'b0;
`endif
                    end else if (fail_q == FAIL_LAST) begin
                        fail_d   = '0;
                        tmr_load = 1'b1;
                        tmr_val  = LOCKOUT_LD;
                        state_d  = LOCKOUT;
`ifdef SAFE_LOCK_ALARM_EN
                        alarm_d  = 1'b1;
`endif
                    end else begin
                        fail_d = fail_q + 1'b1;
                    end
                end
            end
            UNLOCKED: begin
                // Relock and expiry together are one exit, not two.
                if (tmr_zero || relock) begin
                    state_d = ARMED;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            LOCKOUT: begin
                if (tmr_zero) begin
                    state_d = ARMED;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: begin
                // Unreachable encoding: recover to the reset picture.
                state_d  = ARMED;
                fail_d   = '0;
                tmr_load = 1'b1;
                tmr_val  = '0;
`ifdef SAFE_LOCK_ALARM_EN
                alarm_d  = 1'b0;
`endif
            end
        endcase
    end

    // Outputs are flops decoded from the next state so they change in the
    // cycle after the verdict, with no combinational path from inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARMED;
            fail_q       <= '0;
            result_val_q <= 1'b0;
            input_en_q   <= 1'b1;
            unlock_q     <= 1'b0;
            lockout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            fail_q       <= fail_d;
            result_val_q <= result_val;
            input_en_q   <= (state_d == ARMED);
            unlock_q     <= (state_d == UNLOCKED);
            lockout_q    <= (state_d == LOCKOUT);
        end
    end

`ifdef SAFE_LOCK_ALARM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
        end
    end
    assign alarm = alarm_q;
`endif

    assign input_en = input_en_q;
    assign unlock   = unlock_q;
    assign lockout  = lockout_q;
    assign fail_cnt = fail_q;

endmodule

// File: tb/tb_safe_lock_ctrl.sv
// Directed testbench for safe_lock_ctrl with default parameters
// (MAX_ATTEMPTS=3, UNLOCK_CYCLES=16, LOCKOUT_CYCLES=64).
module tb_safe_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       result_val = 1'b0;
    logic       result_data = 1'b0;
    logic       relock = 1'b0;
    logic       input_en, unlock, lockout;
    logic [1:0] fail_cnt;
`ifdef SAFE_LOCK_ALARM_EN
    logic       alarm;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    safe_lock_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .result_val  (result_val),
        .result_data (result_data),
        .relock      (relock),
        .input_en    (input_en),
        .unlock      (unlock),
        .lockout     (lockout),
`ifdef SAFE_LOCK_ALARM_EN
        .fail_cnt    (fail_cnt),
        .alarm       (alarm)
`else
        .fail_cnt    (fail_cnt)
`endif
    );

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; result_val = 1'b0; result_data = 1'b0; relock = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        total++;
        if ({input_en, unlock, lockout, fail_cnt} !== 5'b10000) begin
            bad++; $display("FAIL reset_in: got {en,unl,lck,cnt}=%b want 10000", {input_en, unlock, lockout, fail_cnt});
        end
        rst = 1'b0;
        tick();
        total++;
        if ({input_en, unlock, lockout, fail_cnt} !== 5'b10000) begin
            bad++; $display("FAIL reset_out: got {en,unl,lck,cnt}=%b want 10000", {input_en, unlock, lockout, fail_cnt});
        end
`ifdef SAFE_LOCK_ALARM_EN
        total++;
        if (alarm !== 1'b0) begin bad++; $display("FAIL reset_alarm: got %b want 0", alarm); end
`endif
    endtask

    task automatic test_correct();
        do_reset();
        result_val = 1'b1; result_data = 1'b1;
        tick();
        result_val = 1'b0;
        for (int i = 0; i < 16; i++) begin
            // A wrong verdict during the unlock window must be ignored.
            if (i == 6) begin result_val = 1'b1; result_data = 1'b0; end
            if (i == 8) result_val = 1'b0;
            total++;
            if ({unlock, input_en, fail_cnt} !== 4'b1000) begin
                bad++; $display("FAIL unlock_win[%0d]: got {unl,en,cnt}=%b want 1000", i, {unlock, input_en, fail_cnt});
            end
            tick();
        end
        total++;
        if ({unlock, input_en, fail_cnt} !== 4'b0100) begin
            bad++; $display("FAIL unlock_end: got {unl,en,cnt}=%b want 0100", {unlock, input_en, fail_cnt});
        end
    endtask

    task automatic wrong_pulse(input logic [1:0] exp_cnt, input string name);
        result_val = 1'b1; result_data = 1'b0;
        tick();
        result_val = 1'b0;
        tick();
        total++;
        if ({fail_cnt, input_en, lockout} !== {exp_cnt, 2'b10}) begin
            bad++; $display("FAIL %s: got {cnt,en,lck}=%b want %b", name, {fail_cnt, input_en, lockout}, {exp_cnt, 2'b10});
        end
    endtask

    task automatic test_lockout();
        do_reset();
        wrong_pulse(2'd1, "wrong1");
        wrong_pulse(2'd2, "wrong2");
        result_val = 1'b1; result_data = 1'b0;
        tick();
        result_val = 1'b0;
        for (int i = 0; i < 64; i++) begin
            // Verdicts and relock during lockout must have no effect.
            if (i == 10) begin result_val = 1'b1; result_data = 1'b1; end
            if (i == 12) result_val = 1'b0;
            relock = (i == 20 || i == 21);
            total++;
            if ({lockout, input_en, unlock, fail_cnt} !== 5'b10000) begin
                bad++; $display("FAIL lockout_win[%0d]: got {lck,en,unl,cnt}=%b want 10000", i, {lockout, input_en, unlock, fail_cnt});
            end
            tick();
        end
        relock = 1'b0;
        total++;
        if ({lockout, input_en, unlock, fail_cnt} !== 5'b01000) begin
            bad++; $display("FAIL lockout_end: got {lck,en,unl,cnt}=%b want 01000", {lockout, input_en, unlock, fail_cnt});
        end
`ifdef SAFE_LOCK_ALARM_EN
        total++;
        if (alarm !== 1'b1) begin bad++; $display("FAIL alarm_sticky: got %b want 1", alarm); end
        tick(); tick();
        total++;
        if (alarm !== 1'b1) begin bad++; $display("FAIL alarm_hold: got %b want 1", alarm); end
        result_val = 1'b1; result_data = 1'b1;
        tick();
        result_val = 1'b0;
        total++;
        if ({alarm, unlock} !== 2'b01) begin
            bad++; $display("FAIL alarm_clear: got {alarm,unl}=%b want 01", {alarm, unlock});
        end
`endif
    endtask

    task automatic test_wrong_wrong_correct();
        do_reset();
        wrong_pulse(2'd1, "wwc_1");
        wrong_pulse(2'd2, "wwc_2");
        result_val = 1'b1; result_data = 1'b1;
        tick();
        result_val = 1'b0;
        total++;
        if ({unlock, input_en, fail_cnt} !== 4'b1000) begin
            bad++; $display("FAIL wwc_correct: got {unl,en,cnt}=%b want 1000", {unlock, input_en, fail_cnt});
        end
    endtask

    task automatic test_held_verdict();
        do_reset();
        result_val = 1'b1; result_data = 1'b0;
        tick();
        total++;
        if (fail_cnt !== 2'd1) begin bad++; $display("FAIL held_c1: got %0d want 1", fail_cnt); end
        tick();
        total++;
        if (fail_cnt !== 2'd1) begin bad++; $display("FAIL held_c2: got %0d want 1", fail_cnt); end
        result_val = 1'b0;
        tick();
        total++;
        if (fail_cnt !== 2'd1) begin bad++; $display("FAIL held_after: got %0d want 1", fail_cnt); end
    endtask

    task automatic test_relock();
        do_reset();
        result_val = 1'b1; result_data = 1'b1;
        tick();
        result_val = 1'b0;
        tick(); tick(); tick(); tick();
        total++;
        if (unlock !== 1'b1) begin bad++; $display("FAIL relock_pre: got %b want 1", unlock); end
        relock = 1'b1;
        tick();
        relock = 1'b0;
        total++;
        if ({unlock, input_en} !== 2'b01) begin
            bad++; $display("FAIL relock_drop: got {unl,en}=%b want 01", {unlock, input_en});
        end
        tick();
        total++;
        if ({unlock, input_en} !== 2'b01) begin
            bad++; $display("FAIL relock_stay: got {unl,en}=%b want 01", {unlock, input_en});
        end
    endtask

    task automatic test_relock_at_expiry();
        do_reset();
        result_val = 1'b1; result_data = 1'b1;
        tick();
        result_val = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        total++;
        if (unlock !== 1'b1) begin bad++; $display("FAIL expiry_last: got %b want 1", unlock); end
        relock = 1'b1;
        tick();
        relock = 1'b0;
        total++;
        if ({unlock, input_en, lockout} !== 3'b010) begin
            bad++; $display("FAIL expiry_relock: got {unl,en,lck}=%b want 010", {unlock, input_en, lockout});
        end
        tick();
        total++;
        if ({unlock, input_en} !== 2'b01) begin
            bad++; $display("FAIL expiry_after: got {unl,en}=%b want 01", {unlock, input_en});
        end
    endtask

    task automatic test_back_to_back_held();
        // result_val held through the whole unlock must not re-trigger it.
        do_reset();
        result_val = 1'b1; result_data = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) tick();
        total++;
        if ({unlock, input_en} !== 2'b01) begin
            bad++; $display("FAIL held_return: got {unl,en}=%b want 01", {unlock, input_en});
        end
        tick(); tick(); tick();
        total++;
        if ({unlock, input_en, fail_cnt} !== 4'b0100) begin
            bad++; $display("FAIL held_no_retrig: got {unl,en,cnt}=%b want 0100", {unlock, input_en, fail_cnt});
        end
        result_val = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        wrong_pulse(2'd1, "rm_w1");
        wrong_pulse(2'd2, "rm_w2");
        result_val = 1'b1; result_data = 1'b0;
        tick();
        result_val = 1'b0;
        tick(); tick(); tick();
        total++;
        if (lockout !== 1'b1) begin bad++; $display("FAIL rm_in_lockout: got %b want 1", lockout); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({lockout, input_en, fail_cnt} !== 4'b0100) begin
            bad++; $display("FAIL rm_lockout: got {lck,en,cnt}=%b want 0100", {lockout, input_en, fail_cnt});
        end
`ifdef SAFE_LOCK_ALARM_EN
        total++;
        if (alarm !== 1'b0) begin bad++; $display("FAIL rm_alarm: got %b want 0", alarm); end
`endif
        // Reset in the middle of an unlock window.
        wrong_pulse(2'd1, "rm_w3");
        result_val = 1'b1; result_data = 1'b1;
        tick();
        result_val = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({unlock, input_en, fail_cnt} !== 4'b0100) begin
            bad++; $display("FAIL rm_unlock: got {unl,en,cnt}=%b want 0100", {unlock, input_en, fail_cnt});
        end
    endtask

    initial begin
        test_reset();
        test_correct();
        test_lockout();
        test_wrong_wrong_correct();
        test_held_verdict();
        test_relock();
        test_relock_at_expiry();
        test_back_to_back_held();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
